seg_display_scanner: RTL

Parametrised multiplexed seven-segment display driver for the calculator result path. It accepts an unsigned binary result and a sign flag on a one-cycle load strobe, then converts the value to BCD with a sequential double-dabble engine. It applies leading-zero blanking, minus-sign placement and overflow dashes, and time-multiplexes the digits onto one shared segment bus plus per-digit anode enables. It sits between the ALU result register and the board display pins and replaces the separate combinational encoder/digit decoder pair.

---
 rtl/seg_display_scanner_if.sv | 24 ++
 rtl/seg_display_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner_if.sv
// Result-path bundle between the ALU result register and the display scanner.
// The master side presents a value on a load strobe; the slave side drives the display pins.
interface seg_display_scanner_if #(
   parameter int NUM_DIGITS = 4,
   parameter int IN_WIDTH   = 20
);
   logic                  load;
   logic [IN_WIDTH-1:0]   value;
   logic                  neg;
   logic                  busy;
   logic                  overflow;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;

   modport master (
      output load, value, neg,
      input  busy, overflow, seg, an
   );

   modport slave (
      input  load, value, neg,
      output busy, overflow, seg, an
   );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment driver: sequential double-dabble conversion, blanking,
// minus-sign and overflow handling, and a free-running digit scanner.
module seg_display_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int IN_WIDTH    = 20,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input logic                  clk,
   input logic                  reset,
   seg_display_scanner_if.slave bus
);
   localparam int BCD_W  = 4*NUM_DIGITS + 4;
   localparam int STEP_W = $clog2(IN_WIDTH + 1);
   localparam int REF_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(IN_WIDTH - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   localparam logic [3:0] SYM_DASH  = 4'd10;
   localparam logic [3:0] SYM_BLANK = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] shift_q;
   logic [BCD_W-1:0]    bcd_q, bcd_adj;
   logic                carry_q;
   logic                neg_q;
   logic [STEP_W-1:0]   step_q;
   logic                overflow_q;
   logic [3:0]          sym_q    [NUM_DIGITS];
   logic [3:0]          sym_next [NUM_DIGITS];
   logic [NUM_DIGITS:0] nz;
   logic [NUM_DIGITS-1:0] shown;
   logic                seen;
   logic                ovf_next;
   logic [REF_W-1:0]    refresh_q;
   logic [IDX_W-1:0]    idx_q;
   logic [6:0]          seg_raw;
   logic [NUM_DIGITS-1:0] an_raw;

   function automatic logic [6:0] seg_of(input logic [3:0] sym);
      case (sym)
         4'd0:    seg_of = 7'h3F;
         4'd1:    seg_of = 7'h06;
         4'd2:    seg_of = 7'h5B;
         4'd3:    seg_of = 7'h4F;
         4'd4:    seg_of = 7'h66;
         4'd5:    seg_of = 7'h6D;
         4'd6:    seg_of = 7'h7D;
         4'd7:    seg_of = 7'h07;
         4'd8:    seg_of = 7'h7F;
         4'd9:    seg_of = 7'h6F;
         4'd10:   seg_of = 7'h40;
         default: seg_of = 7'h00;
      endcase
   endfunction

   // NOTE: the state register uses non-blocking assignments; all decode lives in always_comb with defaults first so no latch is inferred.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (bus.load) state_d = S_CONVERT;
         S_CONVERT: if (step_q == LAST_STEP) state_d = S_COMMIT;
         S_COMMIT:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i <= NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // carry_q catches digits pushed beyond the top nibble, so huge values still flag overflow.
   always_comb begin
      for (int i = 0; i <= NUM_DIGITS; i++) nz[i] = |bcd_q[4*i +: 4];
      ovf_next = carry_q | nz[NUM_DIGITS] | (neg_q & nz[NUM_DIGITS-1]);
      seen = 1'b0;
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
         seen     = seen | nz[i] | (i == 0);
         shown[i] = seen;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ovf_next)      sym_next[i] = SYM_DASH;
         else if (shown[i]) sym_next[i] = bcd_q[4*i +: 4];
         else               sym_next[i] = SYM_BLANK;
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (!ovf_next && neg_q && !shown[i] && shown[i-1]) sym_next[i] = SYM_DASH;
      end
   end

   // NOTE: the digit registers are reset explicitly because a blank display after reset is required behaviour.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q    <= '0;
         bcd_q      <= '0;
         carry_q    <= 1'b0;
         neg_q      <= 1'b0;
         step_q     <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) sym_q[i] <= SYM_BLANK;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.load) begin
                  shift_q <= bus.value;
                  neg_q   <= bus.neg;
                  bcd_q   <= '0;
                  carry_q <= 1'b0;
                  step_q  <= '0;
               end
            end
            S_CONVERT: begin
               bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[IN_WIDTH-1]};
               shift_q <= {shift_q[IN_WIDTH-2:0], 1'b0};
               carry_q <= carry_q | bcd_adj[BCD_W-1];
               step_q  <= step_q + STEP_W'(1);
            end
            S_COMMIT: begin
               overflow_q <= ovf_next;
               sym_q      <= sym_next;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_q <= '0;
         idx_q     <= '0;
      end else if (refresh_q == REF_LAST) begin
         refresh_q <= '0;
         idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         refresh_q <= refresh_q + REF_W'(1);
      end
   end

   always_comb begin
      seg_raw = seg_of(sym_q[idx_q]);
      an_raw  = NUM_DIGITS'(1) << idx_q;
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.overflow = overflow_q;
   assign bus.seg      = ACTIVE_LOW ? ~seg_raw : seg_raw;
   assign bus.an       = ACTIVE_LOW ? ~an_raw  : an_raw;
endmodule
